// File: rtl/calc_sequencer.sv
// Two-operand 4-bit add/subtract sequencer driven by a single debounced pushbutton.
// Each press steps LOAD_A -> LOAD_B -> COMPUTE -> SHOW and back to LOAD_A.
module calc_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [3:0] sw_data,
  input  logic       sw_sub,
  output logic [3:0] disp_a,
  output logic [3:0] disp_b,
  output logic [3:0] disp_r,
  output logic       cout,
  output logic       ovf,
  output logic       result_valid,
  output logic [1:0] state_led
);

  localparam logic [1:0] LOAD_A  = 2'b00;
  localparam logic [1:0] LOAD_B  = 2'b01;
  localparam logic [1:0] COMPUTE = 2'b10;
  localparam logic [1:0] SHOW    = 2'b11;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_p0, key_p1;
  logic             key_acc, key_acc_d;
  logic [CNT_W-1:0] db_cnt;
  logic             press;
  logic [1:0]       state;
  logic [3:0]       a_q, b_q;
  logic             op_q;

  // Returns {carry, overflow, sum}; subtraction is A + ~B + 1.
  function automatic logic [5:0] addsub(input logic [3:0] a, input logic [3:0] b,
                                        input logic sub);
    logic [3:0] bx;
    logic [4:0] sum;
    bx  = b ^ {4{sub}};
    sum = {1'b0, a} + {1'b0, bx} + {4'b0000, sub};
    return {sum[4], (a[3] == bx[3]) && (sum[3] != a[3]), sum[3:0]};
  endfunction

  // Synchronizer stage: idles at the released level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= key_n;
      key_p1 <= key_p0;
    end
  end

  // Debounce stage: accept a new level only after CNT_MAX+1 consecutive differing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_acc   <= 1'b1;
      key_acc_d <= 1'b1;
      db_cnt    <= '0;
    end else begin
      key_acc_d <= key_acc;
      if (key_p1 == key_acc) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        key_acc <= key_p1;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = key_acc_d & ~key_acc;

  // Sequencer stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD_A;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      disp_r       <= '0;
      cout         <= 1'b0;
      ovf          <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (press) begin
          a_q   <= sw_data;
          state <= LOAD_B;
        end
        LOAD_B: if (press) begin
          b_q   <= sw_data;
          op_q  <= sw_sub;
          state <= COMPUTE;
        end
        COMPUTE: begin
          {cout, ovf, disp_r} <= addsub(a_q, b_q, op_q);
          result_valid        <= 1'b1;
          state               <= SHOW;
        end
        default: if (press) begin
          result_valid <= 1'b0;
          state        <= LOAD_A;
        end
      endcase
    end
  end

  assign disp_a    = a_q;
  assign disp_b    = b_q;
  assign state_led = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with DEBOUNCE_CYCLES=4: a scoreboard queue holds
// hand-computed results, and a monitor checks them whenever result_valid rises.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic [3:0] sw_data;
  logic       sw_sub;
  logic [3:0] disp_a, disp_b, disp_r;
  logic       cout, ovf, result_valid;
  logic [1:0] state_led;

  typedef struct packed {
    logic [3:0] r;
    logic       c;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  calc_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw_data(sw_data), .sw_sub(sw_sub),
    .disp_a(disp_a), .disp_b(disp_b), .disp_r(disp_r), .cout(cout), .ovf(ovf),
    .result_valid(result_valid), .state_led(state_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each new result against the oldest queued expectation
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (result_valid && !vprev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("disp_r", {12'd0, disp_r}, {12'd0, e.r});
        check("cout", {15'd0, cout}, {15'd0, e.c});
        check("ovf", {15'd0, ovf}, {15'd0, e.v});
        check("state_show", {14'd0, state_led}, 16'd3);
      end
    end
    vprev <= result_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input int hold);
    @(negedge clk) key_n = 1'b0;
    tick(hold);
    @(negedge clk) key_n = 1'b1;
    tick(10);
  endtask

  task automatic load_a(input logic [3:0] a);
    sw_data = a;
    press_release(10);
    check("disp_a", {12'd0, disp_a}, {12'd0, a});
    check("state_load_b", {14'd0, state_led}, 16'd1);
  endtask

  // B press with latency check; the switches change right after the press
  task automatic load_b(input logic [3:0] b, input logic sub, input exp_t e);
    sw_data = b;
    sw_sub  = sub;
    exp_q.push_back(e);
    @(negedge clk) key_n = 1'b0;
    tick(7);
    check("state_compute", {14'd0, state_led}, 16'd2);
    check("valid_in_compute", {15'd0, result_valid}, 16'd0);
    sw_data = ~b;
    sw_sub  = ~sub;
    tick(1);
    check("state_show", {14'd0, state_led}, 16'd3);
    check("valid_latency", {15'd0, result_valid}, 16'd1);
    tick(2);
    @(negedge clk) key_n = 1'b1;
    tick(10);
    check("disp_b", {12'd0, disp_b}, {12'd0, b});
  endtask

  task automatic show_exit(input logic [3:0] r_hold);
    press_release(10);
    check("state_load_a", {14'd0, state_led}, 16'd0);
    check("valid_cleared", {15'd0, result_valid}, 16'd0);
    check("disp_r_held", {12'd0, disp_r}, {12'd0, r_hold});
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {disp_a, disp_b, disp_r, cout, ovf, result_valid, state_led}, 16'd0);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    exp_t       e;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'h5, 4'h3, 1'b0, '{4'h8, 1'b0, 1'b1}};
    vecs[1] = '{4'h3, 4'h5, 1'b1, '{4'hE, 1'b0, 1'b0}};
    vecs[2] = '{4'hF, 4'h1, 1'b0, '{4'h0, 1'b1, 1'b0}};
    vecs[3] = '{4'h7, 4'h8, 1'b1, '{4'hF, 1'b0, 1'b1}};
    vecs[4] = '{4'h6, 4'h2, 1'b1, '{4'h4, 1'b1, 1'b0}};

    rst_n   = 1'b0;
    key_n   = 1'b1;
    sw_data = 4'h0;
    sw_sub  = 1'b0;
    #1;
    check_reset_outputs("reset_state");
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    foreach (vecs[i]) begin
      load_a(vecs[i].a);
      load_b(vecs[i].b, vecs[i].sub, vecs[i].e);
      show_exit(vecs[i].e.r);
    end

    // Short glitch is rejected
    @(negedge clk) key_n = 1'b0;
    tick(3);
    @(negedge clk) key_n = 1'b1;
    tick(15);
    check("glitch_state", {14'd0, state_led}, 16'd0);

    // Long hold advances exactly once; switches alone change nothing
    sw_data = 4'h9;
    press_release(100);
    check("long_hold_state", {14'd0, state_led}, 16'd1);
    check("long_hold_a", {12'd0, disp_a}, 16'h9);
    sw_data = 4'h2;
    sw_sub  = 1'b1;
    tick(20);
    check("sw_idle_a", {12'd0, disp_a}, 16'h9);
    check("sw_idle_b", {12'd0, disp_b}, 16'h2);
    check("sw_idle_state", {14'd0, state_led}, 16'd1);

    // Reset during COMPUTE: no result may appear
    sw_data = 4'h3;
    sw_sub  = 1'b0;
    @(negedge clk) key_n = 1'b0;
    tick(7);
    check("pre_reset_compute", {14'd0, state_led}, 16'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_compute");
    key_n = 1'b1;
    tick(3);
    @(negedge clk) rst_n = 1'b1;
    tick(12);
    check_reset_outputs("after_compute_reset");

    // Reset during SHOW with the key still held
    load_a(4'h4);
    sw_data = 4'h1;
    sw_sub  = 1'b0;
    exp_q.push_back('{4'h5, 1'b0, 1'b0});
    @(negedge clk) key_n = 1'b0;
    tick(9);
    check("pre_reset_show", {14'd0, state_led}, 16'd3);
    rst_n   = 1'b0;
    sw_data = 4'h4;
    #1;
    check_reset_outputs("reset_in_show");
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(6);
    check("held_key_no_early_press", {14'd0, state_led}, 16'd0);
    tick(1);
    check("held_key_full_debounce", {14'd0, state_led}, 16'd1);
    check("held_key_a", {12'd0, disp_a}, 16'h4);
    @(negedge clk) key_n = 1'b1;
    tick(10);
    load_b(4'h3, 1'b0, '{4'h7, 1'b0, 1'b0});
    show_exit(4'h7);

    tick(5);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
